// File: rtl/mac_arbiter_pkg.sv
// mac_arbiter_pkg
//   Shared constants and types for the two-requester MAC arbiter:
//   requester count, operand/result widths, FIFO sizing limits,
//   the requester-id type, the tag-pipeline stage struct and a
//   ring-pointer increment helper used by the response FIFOs.
package mac_arbiter_pkg;

  localparam int NUM_REQ   = 2;
  localparam int OP_W      = 4;
  localparam int RES_W     = 8;
  // Largest legal response FIFO depth; storage is always sized to this.
  localparam int MAX_DEPTH = 4;
  localparam int PTR_W     = 2;
  // Wide enough to hold a count of 0..MAX_DEPTH.
  localparam int CNT_W     = 3;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Advance a ring pointer, wrapping after slot depth-1.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                 input int               depth);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_W'(depth - 1)) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mac_rsp_fifo.sv
// mac_rsp_fifo
//   Per-requester response FIFO holding 8-bit MAC results.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     i_push/i_wdata  write a result (must not target a full FIFO
//                     unless a pop happens in the same cycle)
//     i_pop           remove the head entry (ignored when empty)
//     o_data          head entry, 0 while empty
//     o_valid         FIFO non-empty
//     o_count         number of stored entries
module mac_rsp_fifo
  import mac_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [RES_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [RES_W-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [RES_W-1:0] r_mem [MAX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Result storage; cleared on reset so no stale data survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        r_mem[i] <= {RES_W{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Read/write ring pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr, DEPTH);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr, DEPTH);
      end
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_count = r_count;
  assign o_data  = w_empty ? {RES_W{1'b0}} : r_mem[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_push && w_full && !w_do_pop))
    else $error("mac_rsp_fifo: write into full FIFO");

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter
//   Round-robin arbiter sharing one external MAC (a*b+c, 8-bit result)
//   between two requesters, with credit-based flow control into a
//   per-requester response FIFO.
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     req_valid/req_ready      per-requester operand handshake
//     req_a/b/c                packed 4-bit operands, [3:0] req0, [7:4] req1
//     rsp_valid/rsp_ready      per-requester result handshake
//     rsp_data                 packed 8-bit results, [7:0] req0, [15:8] req1
//     mac_a/b/c                operands to the shared MAC (0 when idle)
//     mac_result               MAC output, MAC_LATENCY cycles after issue
//     busy                     operation in flight or a FIFO non-empty
module mac_arbiter
  import mac_arbiter_pkg::*;
#(
  parameter int MAC_LATENCY = 1,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_a,
  input  logic [NUM_REQ*OP_W-1:0]  req_b,
  input  logic [NUM_REQ*OP_W-1:0]  req_c,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ*RES_W-1:0] rsp_data,
  output logic [OP_W-1:0]          mac_a,
  output logic [OP_W-1:0]          mac_b,
  output logic [OP_W-1:0]          mac_c,
  input  logic [RES_W-1:0]         mac_result,
  output logic                     busy
);

  localparam int USE_W = CNT_W + 1;

  tag_t    r_tag [MAC_LATENCY];
  req_id_t r_last_grant;

  tag_t                 w_tail;
  tag_t                 w_issue_tag;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_issue;
  logic [NUM_REQ-1:0]   w_push;
  logic [NUM_REQ-1:0]   w_pop;
  logic [NUM_REQ-1:0]   w_fifo_valid;
  logic [CNT_W-1:0]     w_fifo_count [NUM_REQ];
  logic [CNT_W-1:0]     w_inflight   [NUM_REQ];
  logic [USE_W-1:0]     w_used       [NUM_REQ];
  logic [USE_W-1:0]     w_limit      [NUM_REQ];
  logic                 w_any_inflight;

  assign w_tail = r_tag[MAC_LATENCY-1];
  assign w_pop  = w_fifo_valid & rsp_ready;

  // Count tagged operations per requester that are still inside the MAC.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_inflight[i] = {CNT_W{1'b0}};
      for (int k = 0; k < MAC_LATENCY; k++) begin
        if (r_tag[k].valid && (r_tag[k].id == req_id_t'(i))) begin
          w_inflight[i] = w_inflight[i] + 3'd1;
        end else begin
          w_inflight[i] = w_inflight[i];
        end
      end
    end
  end

  // Credit check: a requester may issue while buffered plus in-flight
  // results stay below the FIFO depth. A pop this cycle frees one slot,
  // which is what lets a single requester issue every cycle.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_used[i]  = {1'b0, w_fifo_count[i]} + {1'b0, w_inflight[i]};
      w_limit[i] = USE_W'(RSP_DEPTH) + {{(USE_W-1){1'b0}}, w_pop[i]};
      w_elig[i]  = !reset && req_valid[i] && (w_used[i] < w_limit[i]);
    end
  end

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    w_grant = 2'b00;
    if (w_elig[0] && w_elig[1]) begin
      w_grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
    end else if (w_elig[0]) begin
      w_grant = 2'b01;
    end else if (w_elig[1]) begin
      w_grant = 2'b10;
    end else begin
      w_grant = 2'b00;
    end
  end

  assign w_issue   = |w_grant;
  assign req_ready = w_grant;

  // MAC operand mux; zeros when nothing issues.
  always_comb begin
    mac_a = 4'd0;
    mac_b = 4'd0;
    mac_c = 4'd0;
    if (w_grant[1]) begin
      mac_a = req_a[7:4];
      mac_b = req_b[7:4];
      mac_c = req_c[7:4];
    end else if (w_grant[0]) begin
      mac_a = req_a[3:0];
      mac_b = req_b[3:0];
      mac_c = req_c[3:0];
    end else begin
      mac_a = 4'd0;
      mac_b = 4'd0;
      mac_c = 4'd0;
    end
  end

  // Tag for the operation entering the MAC this cycle.
  always_comb begin
    w_issue_tag       = tag_t'(2'b00);
    w_issue_tag.valid = w_issue;
    w_issue_tag.id    = req_id_t'(w_grant[1]);
  end

  // Tag pipeline aligned with the MAC latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAC_LATENCY; k++) begin
        r_tag[k] <= tag_t'(2'b00);
      end
    end else begin
      r_tag[0] <= w_issue_tag;
      for (int k = 1; k < MAC_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Last-grant pointer; reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_issue) begin
      r_last_grant <= req_id_t'(w_grant[1]);
    end
  end

  // Route the MAC result at the pipeline tail to its requester's FIFO.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_push[i] = w_tail.valid && (w_tail.id == req_id_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    mac_rsp_fifo #(
      .DEPTH (RSP_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_wdata (mac_result),
      .i_pop   (w_pop[g]),
      .o_data  (rsp_data[g*RES_W +: RES_W]),
      .o_valid (w_fifo_valid[g]),
      .o_count (w_fifo_count[g])
    );
  end

  assign rsp_valid = w_fifo_valid;

  // Any valid tag still travelling through the MAC.
  always_comb begin
    w_any_inflight = 1'b0;
    for (int k = 0; k < MAC_LATENCY; k++) begin
      w_any_inflight = w_any_inflight | r_tag[k].valid;
    end
  end

  assign busy = w_any_inflight | (|w_fifo_valid);

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0]  req_a, req_b, req_c, mac_result;
  logic [15:0] rsp_data;
  logic [3:0]  mac_a, mac_b, mac_c;
  logic        busy;

  logic [1:0]  d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready;
  logic [7:0]  d_req_a, d_req_b, d_req_c, d_mac_result;
  logic [15:0] d_rsp_data;
  logic [3:0]  d_mac_a, d_mac_b, d_mac_c;
  logic        d_busy;
  logic [7:0]  d_p1, d_p2;

  int n_checks = 0;
  int n_errors = 0;

  mac_arbiter #(.MAC_LATENCY(1), .RSP_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_result(mac_result), .busy(busy)
  );

  mac_arbiter #(.MAC_LATENCY(3), .RSP_DEPTH(2)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_a(d_req_a), .req_b(d_req_b), .req_c(d_req_c),
    .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready), .rsp_data(d_rsp_data),
    .mac_a(d_mac_a), .mac_b(d_mac_b), .mac_c(d_mac_c),
    .mac_result(d_mac_result), .busy(d_busy)
  );

  // External MAC models: one cycle and three cycles of latency.
  always @(posedge clk) begin
    mac_result   <= {4'd0, mac_a} * {4'd0, mac_b} + {4'd0, mac_c};
    d_p1         <= {4'd0, d_mac_a} * {4'd0, d_mac_b} + {4'd0, d_mac_c};
    d_p2         <= d_p1;
    d_mac_result <= d_p2;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0]  exp_g   [4];
  logic [1:0]  exp_v   [6];
  logic [15:0] exp_d   [6];
  logic [1:0]  exp_s   [6];
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  // Compare one cycle of DUT3 responses against the scoreboard.
  task automatic score_rsp();
    logic [31:0] e;
    if (d_rsp_valid[0] && d_rsp_ready[0]) begin
      e = (q0.size() > 0) ? {24'd0, q0.pop_front()} : 32'h100;
      check_eq("r038_rsp0", {24'd0, d_rsp_data[7:0]}, e);
    end
    if (d_rsp_valid[1] && d_rsp_ready[1]) begin
      e = (q1.size() > 0) ? {24'd0, q1.pop_front()} : 32'h100;
      check_eq("r038_rsp1", {24'd0, d_rsp_data[15:8]}, e);
    end
  endtask

  initial begin
    int n0;
    int issued;
    int cyc;
    int n_both;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_v = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_d = '{16'h0000, 16'h0000, 16'h0002, 16'h0A00, 16'h0008, 16'h1000};
    exp_s = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = 8'h00; req_b = 8'h00; req_c = 8'h00;
    d_req_valid = 2'b00; d_rsp_ready = 2'b00;
    d_req_a = 8'h00; d_req_b = 8'h00; d_req_c = 8'h00;
    tick(); tick();

    // Reset state, with requests pending to show they are not accepted.
    req_valid = 2'b11; req_a = 8'hFF; req_b = 8'hFF; req_c = 8'hFF;
    #1;
    check_eq("rst_req_ready", req_ready, 2'b00);
    check_eq("rst_rsp_valid", rsp_valid, 2'b00);
    check_eq("rst_rsp_data", rsp_data, 16'h0000);
    check_eq("rst_mac_ops", {mac_a, mac_b, mac_c}, 12'h000);
    check_eq("rst_busy", busy, 1'b0);

    // 3*5+2 on requester 0, issued on the first edge after reset release.
    reset = 1'b0; req_valid = 2'b01; req_a = 8'h03; req_b = 8'h05; req_c = 8'h02;
    #1;
    check_eq("s033_ready", req_ready, 2'b01);
    check_eq("s033_mac_ops", {mac_a, mac_b, mac_c}, 12'h352);
    tick();
    req_valid = 2'b00; #1;
    check_eq("s033_no_rsp_yet", rsp_valid, 2'b00);
    check_eq("s033_busy", busy, 1'b1);
    check_eq("s033_idle_mac", {mac_a, mac_b, mac_c}, 12'h000);
    tick(); #1;
    check_eq("s033_rsp_valid", rsp_valid, 2'b01);
    check_eq("s033_rsp_data", rsp_data, 16'h0011);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00; #1;
    check_eq("s033_drained", rsp_valid, 2'b00);
    check_eq("s033_idle_busy", busy, 1'b0);

    // Wrap cases on requester 1: 15*15+15=240, 15*15+0=225; credit limit.
    req_valid = 2'b10; req_a = 8'hF0; req_b = 8'hF0; req_c = 8'hF0; #1;
    check_eq("s035_ready_a", req_ready, 2'b10);
    check_eq("s035_mac_ops", {mac_a, mac_b, mac_c}, 12'hFFF);
    tick();
    req_c = 8'h00; #1;
    check_eq("s035_ready_b", req_ready, 2'b10);
    tick(); #1;
    check_eq("s035_rsp_valid", rsp_valid, 2'b10);
    check_eq("s035_rsp_240", rsp_data, 16'hF000);
    check_eq("s035_no_credit", req_ready, 2'b00);
    tick();
    req_valid = 2'b00; rsp_ready = 2'b10; #1;
    check_eq("s035_head_240", rsp_data, 16'hF000);
    tick(); #1;
    check_eq("s035_rsp_225", rsp_data, 16'hE100);
    tick();
    rsp_ready = 2'b00; #1;
    check_eq("s035_empty", rsp_valid, 2'b00);

    // Both requesters contend for four cycles: alternating grants.
    for (int k = 0; k < 6; k++) begin
      rsp_ready = 2'b11;
      if (k < 4) begin
        req_valid = 2'b11;
        req_a = {4'(k + 2), 4'(k + 1)};
        req_b = {4'd3, 4'd2};
        req_c = {4'd1, 4'(k)};
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (k < 4) check_eq($sformatf("s034_grant%0d", k), req_ready, exp_g[k]);
      check_eq($sformatf("s034_rsp_valid%0d", k), rsp_valid, exp_v[k]);
      check_eq($sformatf("s034_rsp_data%0d", k), rsp_data, exp_d[k]);
      tick();
    end
    #1;
    check_eq("s034_busy", busy, 1'b0);

    // Requester 0 stalled on the response side: two issues, then blocked.
    rsp_ready = 2'b10; req_valid = 2'b11;
    req_a = 8'h11; req_b = 8'h11; req_c = 8'h11;
    n0 = 0;
    for (int s = 0; s < 6; s++) begin
      #1;
      check_eq($sformatf("s036_grant%0d", s), req_ready, exp_s[s]);
      if (req_valid[0] && req_ready[0]) n0++;
      tick();
    end
    check_eq("s036_req0_issues", n0, 2);
    req_valid = 2'b00; rsp_ready = 2'b11;
    for (int s = 0; s < 4; s++) tick();
    #1;
    check_eq("s036_drained", busy, 1'b0);

    // Reset with two operations outstanding, last grant left at requester 0.
    rsp_ready = 2'b00; req_valid = 2'b10; #1;
    check_eq("s037_grant_r1", req_ready, 2'b10);
    tick();
    req_valid = 2'b01; #1;
    check_eq("s037_grant_r0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; #1;
    check_eq("s037_busy_before", busy, 1'b1);
    reset = 1'b1; #1;
    check_eq("s037_busy_reset", busy, 1'b0);
    tick();
    reset = 1'b0; rsp_ready = 2'b11;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_eq($sformatf("s037_no_rsp%0d", s), rsp_valid, 2'b00);
      tick();
    end
    req_valid = 2'b11; #1;
    check_eq("s037_first_tie", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    for (int s = 0; s < 4; s++) tick();

    // Random traffic on the three-cycle-latency instance with a scoreboard.
    issued = 0; cyc = 0; n_both = 0;
    while (issued < 100 && cyc < 4000) begin
      d_req_valid = 2'($urandom_range(0, 3));
      d_rsp_ready = 2'($urandom_range(0, 3));
      d_req_a = 8'($urandom); d_req_b = 8'($urandom); d_req_c = 8'($urandom);
      #1;
      if (d_req_ready == 2'b11) n_both++;
      if (d_req_valid[0] && d_req_ready[0]) begin
        q0.push_back({4'd0, d_req_a[3:0]} * {4'd0, d_req_b[3:0]} + {4'd0, d_req_c[3:0]});
        issued++;
      end
      if (d_req_valid[1] && d_req_ready[1]) begin
        q1.push_back({4'd0, d_req_a[7:4]} * {4'd0, d_req_b[7:4]} + {4'd0, d_req_c[7:4]});
        issued++;
      end
      score_rsp();
      tick();
      cyc++;
    end
    check_eq("r038_issue_count", issued, 100);
    check_eq("r038_both_ready", n_both, 0);
    d_req_valid = 2'b00; d_rsp_ready = 2'b11;
    for (int s = 0; s < 20; s++) begin
      #1;
      score_rsp();
      tick();
    end
    #1;
    check_eq("r038_left_over", q0.size() + q1.size(), 0);
    check_eq("r038_busy", d_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
